// File: rtl/alu_pkg.sv
// Shared op codes, FSM states and op classification for the iterative ALU.
// Used by alu_iter; the muldiv engine itself is op-agnostic.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_AND  = 4'h2,
    OP_ORR  = 4'h3,
    OP_EOR  = 4'h4,
    OP_SLT  = 4'h5,
    OP_MUL  = 4'h6,
    OP_UDIV = 4'h7,
    OP_UMOD = 4'h8
  } alu_op_t;

  typedef enum logic [1:0] {IDLE, CALC, DONE} alu_state_t;

  function automatic logic is_iter(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_UDIV) || (op == OP_UMOD);
  endfunction

endpackage

// File: rtl/seq_muldiv.sv
// Bit-serial unsigned multiply / restoring divide, one step per cycle, WIDTH steps per op.
// go loads operands; step advances; fin flags the last step, whose results are on prod/quo/rem.
module seq_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic             mul,
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             fin,
  output logic             dz,
  output logic [WIDTH-1:0] prod,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] opd;
  logic             mode;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   r_sh;
  logic             ge;
  logic [WIDTH-1:0] diff;

  // Outputs are the post-step values, so the owner can latch the result on the final step.
  // With a zero divisor every trial subtract succeeds: quotient all ones, remainder = dividend.
  always_comb begin
    prod = {acc[WIDTH-2:0], 1'b0} + (sh[WIDTH-1] ? opd : '0);
    r_sh = {acc, sh[WIDTH-1]};
    ge   = r_sh >= {1'b0, opd};
    diff = r_sh[WIDTH-1:0] - opd;
    quo  = {sh[WIDTH-2:0], ge};
    rem  = ge ? diff : r_sh[WIDTH-1:0];
  end

  assign fin = (cnt == '0);
  assign dz  = (opd == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      sh   <= '0;
      acc  <= '0;
      opd  <= '0;
      mode <= 1'b0;
      cnt  <= '0;
    end else if (go) begin
      mode <= mul;
      sh   <= mul ? b : a;
      opd  <= mul ? a : b;
      acc  <= '0;
      cnt  <= CNT_W'(WIDTH - 1);
    end else if (step) begin
      cnt <= cnt - 1'b1;
      sh  <= mode ? {sh[WIDTH-2:0], 1'b0} : quo;
      acc <= mode ? prod : rem;
    end
  end

endmodule

// File: rtl/alu_iter.sv
// Multi-cycle ALU: single-cycle arith/logic (latency 1), MUL/UDIV/UMOD (latency WIDTH+1).
// No backpressure; start is ignored while busy, accepted in IDLE or in the DONE cycle.
module alu_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       f,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y,
  output logic [3:0]       nzcv
);

  alu_state_t       state, state_n;
  logic [3:0]       op_q;
  logic             go, step, load, c_n, v_n, fin, dz;
  logic [WIDTH-1:0] res, prod, quo, rem;
  logic [WIDTH:0]   sum, dif;
  logic             add_v, sub_v;

  assign sum   = {1'b0, a} + {1'b0, b};
  assign dif   = {1'b0, a} - {1'b0, b};
  assign add_v = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  assign sub_v = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
  assign step  = (state == CALC);
  assign busy  = step;
  assign done  = (state == DONE);

  seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk   (clk),
    .reset (reset),
    .go    (go),
    .mul   (f == OP_MUL),
    .step  (step),
    .a     (a),
    .b     (b),
    .fin   (fin),
    .dz    (dz),
    .prod  (prod),
    .quo   (quo),
    .rem   (rem)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    go      = 1'b0;
    load    = 1'b0;
    res     = '0;
    c_n     = 1'b0;
    v_n     = 1'b0;
    case (state)
      CALC: begin
        if (fin) begin
          load    = 1'b1;
          state_n = DONE;
          case (op_q)
            OP_MUL:  res = prod;
            OP_UDIV: res = quo;
            default: res = rem;
          endcase
          v_n = (op_q != OP_MUL) && dz;
        end
      end
      default: begin
        state_n = IDLE;
        if (start) begin
          if (is_iter(f)) begin
            go      = 1'b1;
            state_n = CALC;
          end else begin
            load    = 1'b1;
            state_n = DONE;
            case (f)
              OP_ADD: begin res = sum[WIDTH-1:0]; c_n = sum[WIDTH];  v_n = add_v; end
              OP_SUB: begin res = dif[WIDTH-1:0]; c_n = ~dif[WIDTH]; v_n = sub_v; end
              OP_AND: res = a & b;
              OP_ORR: res = a | b;
              OP_EOR: res = a ^ b;
              // Signed less-than is N xor V of the subtraction.
              OP_SLT: begin
                res = {{(WIDTH-1){1'b0}}, dif[WIDTH-1] ^ sub_v};
                c_n = ~dif[WIDTH];
                v_n = sub_v;
              end
              default: res = '0;
            endcase
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q <= '0;
      y    <= '0;
      nzcv <= '0;
    end else begin
      if (go) op_q <= f;
      if (load) begin
        y    <= res;
        nzcv <= {res[WIDTH-1], res == '0, c_n, v_n};
      end
    end
  end

endmodule

// File: tb/tb_alu_iter.sv
// Directed bench for alu_iter (WIDTH=32): cycle-level reference model plus literal result checks.
module tb_alu_iter;

  localparam int W = 32;
  localparam logic [3:0] ADD = 4'h0, SUB = 4'h1, AND_ = 4'h2, ORR = 4'h3, EOR = 4'h4,
                         SLT = 4'h5, MUL = 4'h6, UDIV = 4'h7, UMOD = 4'h8;

  logic          clk, reset, start;
  logic [W-1:0]  a, b, y;
  logic [3:0]    f, nzcv;
  logic          busy, done;

  int total = 0;
  int bad   = 0;

  alu_iter #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .f     (f),
    .busy  (busy),
    .done  (done),
    .y     (y),
    .nzcv  (nzcv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference result {nzcv, y} from plain arithmetic.
  function automatic logic [35:0] model(input logic [31:0] x, input logic [31:0] z, input logic [3:0] op);
    logic [31:0] r;
    logic        c, v;
    longint      sx, sz, s;
    logic [63:0] p;
    r = '0; c = 1'b0; v = 1'b0;
    sx = longint'($signed(x));
    sz = longint'($signed(z));
    case (op)
      ADD: begin
        r = x + z;
        p = {32'b0, x} + {32'b0, z};
        c = p > 64'hFFFF_FFFF;
        s = sx + sz;
        v = s != longint'($signed(r));
      end
      SUB, SLT: begin
        r = x - z;
        c = x >= z;
        s = sx - sz;
        v = s != longint'($signed(r));
        if (op == SLT) r = (sx < sz) ? 32'd1 : 32'd0;
      end
      AND_: r = x & z;
      ORR:  r = x | z;
      EOR:  r = x ^ z;
      MUL: begin
        p = {32'b0, x} * {32'b0, z};
        r = p[31:0];
      end
      UDIV: begin
        if (z == 0) begin r = 32'hFFFF_FFFF; v = 1'b1; end
        else r = x / z;
      end
      UMOD: begin
        if (z == 0) begin r = x; v = 1'b1; end
        else r = x % z;
      end
      default: r = '0;
    endcase
    return {r[31], r == 0, c, v, r};
  endfunction

  // Cycle-level expectation: what the outputs must show after each edge.
  logic          m_valid = 1'b0, m_done = 1'b0, m_busy = 1'b0;
  logic [31:0]   m_y = '0;
  logic [3:0]    m_nzcv = '0;
  logic [35:0]   m_pend = '0;
  int            m_left = 0;

  always @(posedge clk) begin
    m_done = 1'b0;
    if (reset) begin
      m_valid = 1'b1;
      m_left  = 0;
      m_busy  = 1'b0;
      m_y     = '0;
      m_nzcv  = '0;
    end else if (m_left > 0) begin
      m_left--;
      m_busy = m_left > 0;
      if (m_left == 0) begin
        m_done = 1'b1;
        {m_nzcv, m_y} = m_pend;
      end
    end else if (start) begin
      if (f == MUL || f == UDIV || f == UMOD) begin
        m_left = W;
        m_busy = 1'b1;
        m_pend = model(a, b, f);
      end else begin
        m_done = 1'b1;
        {m_nzcv, m_y} = model(a, b, f);
      end
    end else begin
      m_busy = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("cyc done", {31'b0, done}, {31'b0, m_done});
      chk("cyc busy", {31'b0, busy}, {31'b0, m_busy});
      chk("cyc y",    y,             m_y);
      chk("cyc nzcv", {28'b0, nzcv}, {28'b0, m_nzcv});
    end
  end

  task automatic drive(input logic [31:0] aa, input logic [31:0] bb, input logic [3:0] ff);
    @(negedge clk);
    start = 1'b1; a = aa; b = bb; f = ff;
  endtask

  // Issue one op, optionally inject an ADD start at cycle intr_at, then check latency and result.
  task automatic run(input logic [31:0] aa, input logic [31:0] bb, input logic [3:0] ff,
                     input logic [31:0] ey, input logic [3:0] en, input int elat,
                     input int intr_at, input string nm);
    int n, nb;
    drive(aa, bb, ff);
    @(negedge clk);
    start = 1'b0;
    n = 1;
    nb = 0;
    while (!done && n < 200) begin
      if (busy) nb++;
      start = (n == intr_at);
      if (n == intr_at) begin a = '0; b = '0; f = ADD; end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk({nm, " latency"}, n, elat);
    chk({nm, " busy cycles"}, nb, elat - 1);
    chk({nm, " y"}, y, ey);
    chk({nm, " nzcv"}, {28'b0, nzcv}, {28'b0, en});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int seen;
    reset = 1'b1; start = 1'b0; a = '0; b = '0; f = '0;
    repeat (3) @(negedge clk);
    chk("reset busy", {31'b0, busy}, 32'd0);
    chk("reset done", {31'b0, done}, 32'd0);
    chk("reset y", y, 32'd0);
    chk("reset nzcv", {28'b0, nzcv}, 32'd0);
    reset = 1'b0;

    // Back-to-back ADD then SUB: done on two consecutive cycles.
    drive(32'd16, 32'd2, ADD);
    @(negedge clk);
    chk("b2b add done", {31'b0, done}, 32'd1);
    chk("b2b add y", y, 32'd18);
    chk("b2b add nzcv", {28'b0, nzcv}, 32'h0);
    start = 1'b1; f = SUB;
    @(negedge clk);
    start = 1'b0;
    chk("b2b sub done", {31'b0, done}, 32'd1);
    chk("b2b sub y", y, 32'd14);
    chk("b2b sub nzcv", {28'b0, nzcv}, 32'h2);
    @(negedge clk);
    chk("b2b idle done", {31'b0, done}, 32'd0);

    run(32'd2,          32'd16,         SUB,  32'hFFFF_FFF2, 4'b1000, 1, 0, "sub neg");
    run(32'h8000_0000,  32'd1,          SUB,  32'h7FFF_FFFF, 4'b0011, 1, 0, "sub ovf");
    run(32'hFFFF_FFFF,  32'd1,          SLT,  32'd1,         4'b0010, 1, 0, "slt");
    run(32'd1,          32'hFFFF_FFFF,  SLT,  32'd0,         4'b0100, 1, 0, "slt false");
    run(32'h7FFF_FFFF,  32'd1,          ADD,  32'h8000_0000, 4'b1001, 1, 0, "add ovf");
    run(32'hFFFF_FFFF,  32'd1,          ADD,  32'd0,         4'b0110, 1, 0, "add carry");
    run(32'h0000_F0F0,  32'h0000_FF00,  AND_, 32'h0000_F000, 4'b0000, 1, 0, "and");
    run(32'h0000_F0F0,  32'h0000_0F0F,  ORR,  32'h0000_FFFF, 4'b0000, 1, 0, "orr");
    run(32'hFFFF_FFFF,  32'hFFFF_FFFF,  EOR,  32'd0,         4'b0100, 1, 0, "eor");
    run(32'd5,          32'd3,          4'hC, 32'd0,         4'b0100, 1, 0, "reserved");
    run(32'd16,         32'd2,          MUL,  32'd32,        4'b0000, 33, 0, "mul");
    run(32'h0001_0000,  32'h0001_0000,  MUL,  32'd0,         4'b0100, 33, 0, "mul wrap");
    run(32'hFFFF_FFFF,  32'hFFFF_FFFF,  MUL,  32'd1,         4'b0000, 33, 0, "mul max");
    run(32'd16,         32'd2,          UDIV, 32'd8,         4'b0000, 33, 0, "udiv");
    run(32'd17,         32'd2,          UMOD, 32'd1,         4'b0000, 33, 0, "umod");
    run(32'hFFFF_FFFF,  32'd1,          UDIV, 32'hFFFF_FFFF, 4'b1000, 33, 0, "udiv by one");
    run(32'd16,         32'd0,          UDIV, 32'hFFFF_FFFF, 4'b1001, 33, 0, "udiv by zero");
    run(32'd16,         32'd0,          UMOD, 32'd16,        4'b0001, 33, 0, "umod by zero");
    run(32'd100,        32'd7,          UMOD, 32'd2,         4'b0000, 33, 0, "umod 100/7");
    run(32'd100,        32'd7,          UDIV, 32'd14,        4'b0000, 33, 5, "udiv ignore start");

    // Reset in the middle of a multiply.
    drive(32'd16, 32'd2, MUL);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("pre-reset busy", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid reset busy", {31'b0, busy}, 32'd0);
    chk("mid reset done", {31'b0, done}, 32'd0);
    chk("mid reset y", y, 32'd0);
    chk("mid reset nzcv", {28'b0, nzcv}, 32'd0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("no done after reset", seen, 0);
    run(32'd16, 32'd2, ADD, 32'd18, 4'b0000, 1, 0, "add after reset");

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
